// File: rtl/arith_op_sequencer.sv
// Multi-cycle arithmetic sequencer: one-cycle ADD/SUB/INC/DEC, shift-add MUL, restoring DIV.
// Optional macro ARITH_SEQ_MUL_EARLY_TERM_EN ends MUL once the remaining multiplier is zero.
module arith_op_sequencer #(
  parameter int WORD_SIZE = 19,
  parameter int OPC_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OPC_W-1:0]     opcode,
  input  logic [WORD_SIZE-1:0] operand_1,
  input  logic [WORD_SIZE-1:0] operand_2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] result_hi,
  output logic                 carry_out,
  output logic                 div_by_zero,
  output logic                 illegal_op,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam int W2    = 2 * WORD_SIZE;

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_INC = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_DEC = OPC_W'(5);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL_IT, S_DIV_IT} state_t;

  state_t               state_q, state_d;
  logic [OPC_W-1:0]     opc_q, opc_d;
  logic [WORD_SIZE-1:0] a_q, a_d;       // op1; shifts into the quotient during DIV
  logic [WORD_SIZE-1:0] b_q, b_d;       // op2; shifts right as the multiplier during MUL
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]        acc_q, acc_d;
  logic [W2-1:0]        mcand_q, mcand_d;
  logic [WORD_SIZE-1:0] rem_q, rem_d;
  logic                 done_q, done_d;
  logic [WORD_SIZE-1:0] res_q, res_d;
  logic [WORD_SIZE-1:0] hi_q, hi_d;
  logic                 carry_q, carry_d;
  logic                 dbz_q, dbz_d;
  logic                 ill_q, ill_d;

  logic [WORD_SIZE:0]   wide;
  logic [W2-1:0]        acc_sum;
  logic [WORD_SIZE:0]   trial;
  logic [WORD_SIZE:0]   trial_diff;
  logic [WORD_SIZE-1:0] rem_n;
  logic [WORD_SIZE-1:0] quo_n;
  logic                 last_it;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    res_d      = res_q;
    hi_d       = hi_q;
    carry_d    = carry_q;
    dbz_d      = dbz_q;
    ill_d      = ill_q;
    wide       = '0;
    acc_sum    = b_q[0] ? (acc_q + mcand_q) : acc_q;
    trial      = {rem_q, a_q[WORD_SIZE-1]};
    trial_diff = trial - {1'b0, b_q};
    rem_n      = (trial >= {1'b0, b_q}) ? trial_diff[WORD_SIZE-1:0] : trial[WORD_SIZE-1:0];
    quo_n      = {a_q[WORD_SIZE-2:0], (trial >= {1'b0, b_q})};
    last_it    = (cnt_q == CNT_W'(WORD_SIZE - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opc_d   = opcode;
          a_d     = operand_1;
          b_d     = operand_2;
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = {{WORD_SIZE{1'b0}}, operand_1};
          rem_d   = '0;
          carry_d = 1'b0;
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
          if (opcode == OP_MUL)                             state_d = S_MUL_IT;
          else if (opcode == OP_DIV && operand_2 != '0)     state_d = S_DIV_IT;
          else                                              state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        hi_d    = '0;
        carry_d = 1'b0;
        // Only a zero-divisor DIV reaches EXEC; MUL never does.
        case (opc_q)
          OP_ADD: begin
            wide    = {1'b0, a_q} + {1'b0, b_q};
            res_d   = wide[WORD_SIZE-1:0];
            carry_d = wide[WORD_SIZE];
          end
          OP_SUB: begin
            wide    = {1'b0, a_q} - {1'b0, b_q};
            res_d   = wide[WORD_SIZE-1:0];
            carry_d = wide[WORD_SIZE];
          end
          OP_INC: begin
            wide    = {1'b0, a_q} + (WORD_SIZE+1)'(1);
            res_d   = wide[WORD_SIZE-1:0];
            carry_d = wide[WORD_SIZE];
          end
          OP_DEC: begin
            wide    = {1'b0, a_q} - (WORD_SIZE+1)'(1);
            res_d   = wide[WORD_SIZE-1:0];
            carry_d = wide[WORD_SIZE];
          end
          OP_DIV: begin
            res_d = '1;
            hi_d  = a_q;
            dbz_d = 1'b1;
          end
          default: begin
            res_d = '0;
            ill_d = 1'b1;
          end
        endcase
      end

      S_MUL_IT: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
`ifdef ARITH_SEQ_MUL_EARLY_TERM_EN
        if (last_it || b_q[WORD_SIZE-1:1] == '0) begin
`else
        if (last_it) begin
`endif
          state_d = S_IDLE;
          done_d  = 1'b1;
          res_d   = acc_sum[WORD_SIZE-1:0];
          hi_d    = acc_sum[W2-1:WORD_SIZE];
          carry_d = |acc_sum[W2-1:WORD_SIZE];
        end
      end

      S_DIV_IT: begin
        rem_d = rem_n;
        a_d   = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (last_it) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          res_d   = quo_n;
          hi_d    = rem_n;
          carry_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = res_q;
  assign result_hi   = hi_q;
  assign carry_out   = carry_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Self-checking bench for arith_op_sequencer: directed literal cases plus a
// randomized run scored every cycle against a latency/arithmetic reference model.
module tb_arith_op_sequencer;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   opcode = '0;
  logic [W-1:0] operand_1 = '0;
  logic [W-1:0] operand_2 = '0;
  logic         busy, done, carry_out, div_by_zero, illegal_op;
  logic [W-1:0] result, result_hi;
  logic [1:0]   dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  arith_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .operand_1(operand_1), .operand_2(operand_2),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carry_out(carry_out), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // reference model: expected outcome of one op, straight from arithmetic
  task automatic model_op(input logic [4:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic [W-1:0] h, output logic c,
                          output logic z, output logic il, output int lat);
    longint unsigned la, lb, p, mask;
    int hb;
    la = a; lb = b; mask = (64'd1 << W) - 1;
    r = '0; h = '0; c = 1'b0; z = 1'b0; il = 1'b0; lat = 1;
    case (opc)
      5'h00: begin p = la + lb; r = W'(p & mask); c = (p > mask); end
      5'h01: begin r = W'((la - lb) & mask); c = (la < lb); end
      5'h04: begin p = la + 1; r = W'(p & mask); c = (p > mask); end
      5'h05: begin r = W'((la - 1) & mask); c = (la == 0); end
      5'h02: begin
        p = la * lb;
        r = W'(p & mask); h = W'(p >> W); c = ((p >> W) != 0);
        lat = W;
`ifdef ARITH_SEQ_MUL_EARLY_TERM_EN
        hb = -1;
        for (int i = 0; i < W; i++) if (b[i]) hb = i;
        lat = (hb < 0) ? 1 : hb + 1;
`endif
      end
      5'h03: begin
        if (lb == 0) begin r = '1; h = a; z = 1'b1; lat = 1; end
        else begin r = W'(la / lb); h = W'(la % lb); lat = W; end
      end
      default: il = 1'b1;
    endcase
  endtask

  // model state, advanced on each rising edge (or reset)
  bit           m_busy = 0, m_done = 0;
  int           m_left = 0;
  logic [W-1:0] m_res = '0, m_hi = '0, p_res, p_hi;
  logic         m_carry = 0, m_dbz = 0, m_ill = 0, p_carry, p_dbz, p_ill;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_left = 0;
      m_res = '0; m_hi = '0; m_carry = 0; m_dbz = 0; m_ill = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (start) begin
        model_op(opcode, operand_1, operand_2, p_res, p_hi, p_carry, p_dbz, p_ill, m_left);
        m_busy = 1; m_carry = 0; m_dbz = 0; m_ill = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
        m_res = p_res; m_hi = p_hi; m_carry = p_carry; m_dbz = p_dbz; m_ill = p_ill;
      end
    end
  end

  // scoreboard compare, every falling edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("carry_out", carry_out, m_carry);
      check("div_by_zero", div_by_zero, m_dbz);
      check("illegal_op", illegal_op, m_ill);
      if (!m_busy) begin
        check("result", result, m_res);
        check("result_hi", result_hi, m_hi);
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // driver tasks: called #1 after a rising edge while the DUT is idle
  task automatic launch(input logic [4:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; opcode = opc; operand_1 = a; operand_2 = b;
    @(posedge clk); #1;
    start = 1'b0; opcode = 5'($urandom); operand_1 = W'($urandom); operand_2 = W'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat >= 64) begin
        n_total++;
        $display("FAIL wait_done_timeout actual=%0d required=done t=%0t", lat, $time);
        break;
      end
    end
  endtask

  int lat;
  int exp_mul_small_lat;

  initial begin
`ifdef ARITH_SEQ_MUL_EARLY_TERM_EN
    exp_mul_small_lat = 3;
`else
    exp_mul_small_lat = 19;
`endif
    #1 rst = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_flags", {carry_out, div_by_zero, illegal_op}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Test 1: ADD wrap
    launch(5'h00, 19'h7FFFF, 19'h00001);
    check("add_busy_after_accept", busy, 1);
    wait_done(lat);
    check("add_latency", lat, 1);
    check("add_result", result, 0);
    check("add_carry", carry_out, 1);
    check("add_busy_at_done", busy, 0);

    // Test 2: SUB borrow, then back-to-back DEC of 0 in the done cycle
    launch(5'h01, 19'd5, 19'd7);
    wait_done(lat);
    check("sub_result", result, 19'h7FFFE);
    check("sub_borrow", carry_out, 1);
    launch(5'h05, 19'd0, 19'd123);
    wait_done(lat);
    check("dec_b2b_latency", lat, 1);
    check("dec_result", result, 19'h7FFFF);
    check("dec_borrow", carry_out, 1);

    // Test 3: MUL
    launch(5'h02, 19'h7FFFF, 19'h7FFFF);
    wait_done(lat);
    check("mul_max_latency", lat, 19);
    check("mul_max_lo", result, 19'h00001);
    check("mul_max_hi", result_hi, 19'h7FFFE);
    check("mul_max_carry", carry_out, 1);
    @(posedge clk); #1;
    launch(5'h02, 19'd3, 19'd5);
    wait_done(lat);
    check("mul_3x5_latency", lat, exp_mul_small_lat);
    check("mul_3x5_lo", result, 15);
    check("mul_3x5_hi", result_hi, 0);

    // Test 4: DIV
    launch(5'h03, 19'd100, 19'd7);
    wait_done(lat);
    check("div_latency", lat, 19);
    check("div_quot", result, 14);
    check("div_rem", result_hi, 2);
    launch(5'h03, 19'd9, 19'd0);
    wait_done(lat);
    check("dbz_latency", lat, 1);
    check("dbz_result", result, 19'h7FFFF);
    check("dbz_hi", result_hi, 9);
    check("dbz_flag", div_by_zero, 1);

    // Test 5: start pulses mid-MUL ignored
    launch(5'h02, 19'd1234, 19'd567);
    repeat (3) begin
      start = 1'b1; opcode = 5'h00; operand_1 = W'($urandom); operand_2 = W'($urandom);
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
    end
    wait_done(lat);
    check("mul_pulses_lo", result, 19'd175390);
    check("mul_pulses_hi", result_hi, 1);

    // illegal opcode
    launch(5'h1F, 19'd77, 19'd88);
    wait_done(lat);
    check("illegal_latency", lat, 1);
    check("illegal_flag", illegal_op, 1);
    check("illegal_result", result, 0);

    // reset at E0+5 of a DIV aborts it
    launch(5'h03, 19'd100, 19'd7);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_outputs", {result, result_hi, carry_out, div_by_zero, illegal_op}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end

    // randomized free-running traffic, scored by the model every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        6:       opcode = 5'($urandom_range(6, 31));
        7:       opcode = 5'h02;
        default: opcode = 5'($urandom_range(0, 5));
      endcase
      operand_1 = rand_word();
      operand_2 = rand_word();
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
